cache_line_refill: RTL and testbench

//  Memory-side responder for the data cache's 16-word block refill. On a miss request it

---
 rtl/cache_line_refill.sv | 129 ++++++++++++
 tb/tb_cache_line_refill.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/cache_line_refill.sv
// cache_line_refill: 16-word line refill responder with store snooping, cooldown and read timeout
module cache_line_refill #(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        Req,
  input  logic [31:0] ReqA,
  input  logic        WE,
  input  logic [31:0] WA,
  input  logic [31:0] WD,
  output logic        MemRE,
  output logic [31:0] MemA,
  input  logic [31:0] MemRD,
  input  logic        MemValid,
  output logic        Busy,
  output logic        RME,
  output logic [31:0] RMD0,
  output logic [31:0] RMD1,
  output logic [31:0] RMD2,
  output logic [31:0] RMD3,
  output logic [31:0] RMD4,
  output logic [31:0] RMD5,
  output logic [31:0] RMD6,
  output logic [31:0] RMD7,
  output logic [31:0] RMD8,
  output logic [31:0] RMD9,
  output logic [31:0] RMD10,
  output logic [31:0] RMD11,
  output logic [31:0] RMD12,
  output logic [31:0] RMD13,
  output logic [31:0] RMD14,
  output logic [31:0] RMD15,
  output logic        TimeoutErr
);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DELIVER} state_t;
  state_t        state_q;
  logic [25:0]   line_q;
  logic [3:0]    idx_q;
  logic [TW-1:0] timer_q;
  logic [15:0]   mask_q;
  logic          cool_q;
  logic [31:0]   buf_q [16];
  logic [31:0]   rmd_q [16];
  logic [31:0]   buf_d [16];
  logic [31:0]   rmd [16];
  logic          snoop, timeout, unused_ok;
  logic [3:0]    widx;
  assign widx = WA[5:2];
  assign Busy = state_q != IDLE;
  assign RME = state_q == DELIVER;
  assign MemRE = state_q == ISSUE;
  assign MemA = MemRE ? {line_q, idx_q, 2'b00} : '0;
  assign snoop = Busy && WE && WA[31:6] == line_q;
  assign timeout = state_q == WAIT && !MemValid && timer_q == TW'(TIMEOUT_CYC - 1);
  assign TimeoutErr = timeout;
  assign unused_ok = ^{ReqA[5:0], WA[1:0]};
  always_comb begin
    for (int n = 0; n < 16; n++) begin
      buf_d[n] = snoop && widx == 4'(n) ? WD : buf_q[n];
      rmd[n] = RME ? buf_d[n] : rmd_q[n];
    end
  end
  assign RMD0 = rmd[0];
  assign RMD1 = rmd[1];
  assign RMD2 = rmd[2];
  assign RMD3 = rmd[3];
  assign RMD4 = rmd[4];
  assign RMD5 = rmd[5];
  assign RMD6 = rmd[6];
  assign RMD7 = rmd[7];
  assign RMD8 = rmd[8];
  assign RMD9 = rmd[9];
  assign RMD10 = rmd[10];
  assign RMD11 = rmd[11];
  assign RMD12 = rmd[12];
  assign RMD13 = rmd[13];
  assign RMD14 = rmd[14];
  assign RMD15 = rmd[15];
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      line_q <= '0;
      idx_q <= '0;
      timer_q <= '0;
      mask_q <= '0;
      cool_q <= 1'b0;
      for (int n = 0; n < 16; n++) begin
        buf_q[n] <= '0;
        rmd_q[n] <= '0;
      end
    end else begin
      case (state_q)
        IDLE: begin
          cool_q <= 1'b0;
          if (Req && !cool_q) begin
            line_q <= ReqA[31:6];
            idx_q <= '0;
            mask_q <= '0;
            state_q <= ISSUE;
          end
        end
        ISSUE: begin
          timer_q <= '0;
          state_q <= WAIT;
        end
        WAIT: begin
          if (MemValid) begin
            if (!mask_q[idx_q]) buf_q[idx_q] <= MemRD;
            idx_q <= idx_q + 4'd1;
            state_q <= idx_q == 4'd15 ? DELIVER : ISSUE;
          end else if (timeout) state_q <= IDLE;
          else timer_q <= timer_q + TW'(1);
        end
        DELIVER: begin
          rmd_q <= buf_d;
          cool_q <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
      if (snoop) begin
        buf_q[widx] <= WD;
        mask_q[widx] <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_cache_line_refill.sv
// tb_cache_line_refill: directed checks of refill latency, snoop merge, timeout, reset and cooldown
module tb_cache_line_refill;
  logic CLK = 0, RST = 1, Req = 0, WE = 0, MemValid = 0, mem_en = 1, outst = 0, pbusy = 0;
  logic [31:0] ReqA = 0, WA = 0, WD = 0, MemRD = 0, ma, rme_rmd15;
  logic MemRE, Busy, RME, TimeoutErr;
  logic [31:0] MemA;
  logic [31:0] RMD [16];
  int ncmp = 0, nbad = 0, cyc = 0, base = 0, lat = 1;
  int nre = 0, nrme = 0, nterr = 0, viol = 0, rme_cyc = -1, terr_cyc = -1, busy_fall = -1;
  int re_cyc [64];
  logic [31:0] mema_log [64];
  cache_line_refill dut (
    .CLK(CLK), .RST(RST), .Req(Req), .ReqA(ReqA), .WE(WE), .WA(WA), .WD(WD),
    .MemRE(MemRE), .MemA(MemA), .MemRD(MemRD), .MemValid(MemValid), .Busy(Busy), .RME(RME),
    .RMD0(RMD[0]), .RMD1(RMD[1]), .RMD2(RMD[2]), .RMD3(RMD[3]), .RMD4(RMD[4]), .RMD5(RMD[5]),
    .RMD6(RMD[6]), .RMD7(RMD[7]), .RMD8(RMD[8]), .RMD9(RMD[9]), .RMD10(RMD[10]),
    .RMD11(RMD[11]), .RMD12(RMD[12]), .RMD13(RMD[13]), .RMD14(RMD[14]), .RMD15(RMD[15]),
    .TimeoutErr(TimeoutErr)
  );
  always #5 CLK = ~CLK;
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask
  // memory: returns MemRD = address, lat cycles after the read strobe
  initial forever begin
    @(posedge CLK);
    #1;
    MemValid = 0;
    if (MemRE && mem_en) begin
      ma = MemA;
      repeat (lat) @(posedge CLK);
      #1;
      MemValid = 1;
      MemRD = ma;
    end
  end
  // cycle numbering relative to the edge that samples Req (cycle 1 follows it)
  initial forever begin
    @(posedge CLK);
    #3;
    cyc++;
    if (MemValid) outst = 0;
    if (MemRE) begin
      if (outst) viol++;
      outst = 1;
      if (nre < 64) begin
        re_cyc[nre] = cyc - base;
        mema_log[nre] = MemA;
      end
      nre++;
    end
    if (RME) begin
      nrme++;
      rme_cyc = cyc - base;
      rme_rmd15 = RMD[15];
    end
    if (TimeoutErr) begin
      nterr++;
      terr_cyc = cyc - base;
    end
    if (pbusy && !Busy && busy_fall < 0) busy_fall = cyc - base;
    pbusy = Busy;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: got hang want finish");
    $fatal(1, "watchdog");
  end
  task automatic start(input logic [31:0] a, input logic hold);
    @(posedge CLK);
    #1;
    Req = 1;
    ReqA = a;
    base = cyc + 1;
    nre = 0; nrme = 0; nterr = 0; viol = 0; outst = 0;
    busy_fall = -1; rme_cyc = -1; terr_cyc = -1;
    @(posedge CLK);
    #1;
    Req = hold;
  endtask
  task automatic wait_done(input int maxc);
    for (int i = 0; i < maxc && nrme == 0 && nterr == 0; i++) @(posedge CLK);
    repeat (3) @(posedge CLK);
    #1;
    chk("fill_end", 32'(nrme + nterr > 0), 1);
  endtask
  initial begin
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_busy", 32'(Busy), 0);
    chk("rst_memre", 32'(MemRE), 0);
    chk("rst_rme", 32'(RME), 0);
    chk("rst_rmd0", RMD[0], 0);
    chk("rst_rmd15", RMD[15], 0);
    RST = 0;
    lat = 1;
    start(32'h0000_0134, 0);
    wait_done(100);
    chk("t1_nre", nre, 16);
    chk("t1_a0", mema_log[0], 32'h100);
    chk("t1_a1", mema_log[1], 32'h104);
    chk("t1_a15", mema_log[15], 32'h13C);
    chk("t1_rme_cyc", rme_cyc, 33);
    chk("t1_nrme", nrme, 1);
    chk("t1_busy_fall", busy_fall, 34);
    chk("t1_rmd0", RMD[0], 32'h100);
    chk("t1_rmd5", RMD[5], 32'h114);
    chk("t1_rmd15", RMD[15], 32'h13C);
    lat = 3;
    start(32'h0000_0134, 0);
    wait_done(200);
    chk("t2_rme_cyc", rme_cyc, 65);
    chk("t2_busy_fall", busy_fall, 66);
    chk("t2_outstanding", viol, 0);
    chk("t2_rmd7", RMD[7], 32'h11C);
    lat = 1;
    start(32'h0000_0100, 0);
    for (int c = 2; c <= 34; c++) begin
      @(posedge CLK);
      #1;
      WE = c == 2 || c == 4 || c == 10 || c == 33;
      WA = c == 2 ? 32'h108 : c == 4 ? 32'h200 : c == 10 ? 32'h110 : 32'h13C;
      WD = c == 2 ? 32'hDEAD : c == 4 ? 32'hBEEF : c == 10 ? 32'h5555 : 32'hCAFE;
    end
    wait_done(50);
    chk("t3_rme_cyc", rme_cyc, 33);
    chk("t3_rmd0", RMD[0], 32'h100);
    chk("t3_rmd2", RMD[2], 32'hDEAD);
    chk("t3_rmd3", RMD[3], 32'h10C);
    chk("t3_rmd4_same", RMD[4], 32'h5555);
    chk("t3_rmd15_deliver", rme_rmd15, 32'hCAFE);
    chk("t3_rmd15_held", RMD[15], 32'hCAFE);
    mem_en = 0;
    start(32'h0000_0400, 0);
    wait_done(400);
    chk("t4_nterr", nterr, 1);
    chk("t4_terr_cyc", terr_cyc, 256);
    chk("t4_nrme", nrme, 0);
    chk("t4_nre", nre, 1);
    chk("t4_busy", 32'(Busy), 0);
    chk("t4_rmd0_kept", RMD[0], 32'h100);
    mem_en = 1;
    start(32'h0000_0400, 0);
    wait_done(100);
    chk("t4_refill_cyc", rme_cyc, 33);
    chk("t4_refill_rmd0", RMD[0], 32'h400);
    lat = 3;
    start(32'h0000_0800, 0);
    repeat (30) @(posedge CLK);
    #3;
    chk("t5_pre_busy", 32'(Busy), 1);
    RST = 1;
    #1;
    chk("t5_busy", 32'(Busy), 0);
    chk("t5_memre", 32'(MemRE), 0);
    chk("t5_mema", MemA, 0);
    chk("t5_rme", 32'(RME), 0);
    chk("t5_terr", 32'(TimeoutErr), 0);
    chk("t5_rmd0", RMD[0], 0);
    chk("t5_rmd15", RMD[15], 0);
    repeat (4) @(posedge CLK);
    #1;
    RST = 0;
    repeat (3) @(posedge CLK);
    #1;
    chk("t5_late_idle", 32'(Busy), 0);
    chk("t5_nrme", nrme, 0);
    lat = 1;
    start(32'h0000_0800, 0);
    wait_done(100);
    chk("t5_a0", mema_log[0], 32'h800);
    chk("t5_rme_cyc", rme_cyc, 33);
    chk("t5_rmd1", RMD[1], 32'h804);
    start(32'h0000_0134, 1);
    wait_done(100);
    Req = 0;
    for (int i = 0; i < 100 && nrme < 2; i++) @(posedge CLK);
    repeat (5) @(posedge CLK);
    #1;
    chk("t6_last_re", re_cyc[15], 31);
    chk("t6_next_re", re_cyc[16], 36);
    chk("t6_nrme", nrme, 2);
    chk("t6_nre", nre, 32);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
    $finish;
  end
endmodule
